// File: rtl/pipeline_control_sequencer.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: merges load-use, branch,
// mul/div occupancy and data-memory wait into per-stage enables and flushes.
module pipeline_control_sequencer #(
    parameter int MULDIV_LATENCY = 4,
    parameter int STALL_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_use_hazard,
    input  logic                   branch_taken,
    input  logic                   ex_is_muldiv,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   id_ex_en,
    output logic                   ex_mem_en,
    output logic                   mem_wb_en,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   ex_mem_bubble,
    output logic                   muldiv_busy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {RUN, MULDIV, MEMWAIT} state_t;
    typedef enum logic [2:0] {
        ACT_MEMSTALL, ACT_MULSTART, ACT_FLUSH, ACT_LOADUSE, ACT_NORMAL
    } act_t;

    // The first mul/div cycle is spent in RUN, and the release cycle sees cnt=0.
    localparam logic [2:0] CNT_INIT = 3'(MULDIV_LATENCY - 2);

    state_t                 state_reg, state_next;
    logic [2:0]             cnt_reg, cnt_next;
    logic [STALL_CNT_W-1:0] stall_cnt_reg;
    act_t                   act;
    logic                   mem_stall;

    assign mem_stall = mem_req && !mem_ready;

    // Action selection shared by the next-state and output processes.
    always_comb begin
        act = ACT_NORMAL;
        if (branch_taken)
            act = ACT_FLUSH;
        else if (load_use_hazard)
            act = ACT_LOADUSE;
        unique case (state_reg)
            RUN: begin
                if (mem_stall)
                    act = ACT_MEMSTALL;
                else if (ex_is_muldiv)
                    act = ACT_MULSTART;
            end
            MEMWAIT: begin
                if (!mem_ready)
                    act = ACT_MEMSTALL;
                else if (ex_is_muldiv)
                    act = ACT_MULSTART;
            end
            MULDIV: begin
                if (mem_stall)
                    act = ACT_MEMSTALL;
                else if (cnt_reg != 3'd0)
                    act = ACT_MULSTART;
            end
            default: act = ACT_NORMAL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= RUN;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = RUN;
        cnt_next   = cnt_reg;
        if (state_reg == MULDIV) begin
            // A memory stall inside a mul/div holds the countdown rather than leaving MULDIV.
            if (act == ACT_MEMSTALL) begin
                state_next = MULDIV;
            end else if (act == ACT_MULSTART) begin
                state_next = MULDIV;
                cnt_next   = cnt_reg - 3'd1;
            end else begin
                cnt_next = 3'd0;
            end
        end else begin
            if (act == ACT_MEMSTALL) begin
                state_next = MEMWAIT;
            end else if (act == ACT_MULSTART) begin
                state_next = MULDIV;
                cnt_next   = CNT_INIT;
            end
        end
    end

    always_comb begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_en     = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        muldiv_busy   = 1'b0;
        if (!reset) begin
            muldiv_busy = (state_reg == MULDIV) || (act == ACT_MULSTART);
            unique case (act)
                ACT_MEMSTALL: ;
                ACT_MULSTART: begin
                    ex_mem_en     = 1'b1;
                    ex_mem_bubble = 1'b1;
                    mem_wb_en     = 1'b1;
                end
                ACT_FLUSH: begin
                    pc_en       = 1'b1;
                    if_id_en    = 1'b1;
                    id_ex_en    = 1'b1;
                    ex_mem_en   = 1'b1;
                    mem_wb_en   = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                ACT_LOADUSE: begin
                    id_ex_en    = 1'b1;
                    id_ex_flush = 1'b1;
                    ex_mem_en   = 1'b1;
                    mem_wb_en   = 1'b1;
                end
                default: begin
                    pc_en     = 1'b1;
                    if_id_en  = 1'b1;
                    id_ex_en  = 1'b1;
                    ex_mem_en = 1'b1;
                    mem_wb_en = 1'b1;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt_reg <= '0;
        else if (!pc_en && (stall_cnt_reg != {STALL_CNT_W{1'b1}}))
            stall_cnt_reg <= stall_cnt_reg + STALL_CNT_W'(1);
    end

    assign stall_cycles = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_control_sequencer.sv
// Directed vector bench for pipeline_control_sequencer: a cycle-by-cycle table
// plus hand sequences for mid-operation reset and counter saturation.
module tb_pipeline_control_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_use_hazard, branch_taken, ex_is_muldiv, mem_req, mem_ready;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_bubble, muldiv_busy;
    logic [15:0] stall_cycles;
    logic [8:0]  outs;

    int total = 0;
    int bad   = 0;

    pipeline_control_sequencer #(
        .MULDIV_LATENCY(4),
        .STALL_CNT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .load_use_hazard(load_use_hazard),
        .branch_taken(branch_taken),
        .ex_is_muldiv(ex_is_muldiv),
        .mem_req(mem_req),
        .mem_ready(mem_ready),
        .pc_en(pc_en),
        .if_id_en(if_id_en),
        .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush),
        .ex_mem_bubble(ex_mem_bubble),
        .muldiv_busy(muldiv_busy),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                   if_id_flush, id_ex_flush, ex_mem_bubble, muldiv_busy};

    // Output order: {pc,if_id,id_ex,ex_mem,mem_wb, if_id_fl,id_ex_fl,bubble, busy}
    localparam logic [8:0] O_NORM  = 9'b11111_000_0;
    localparam logic [8:0] O_NORMB = 9'b11111_000_1;
    localparam logic [8:0] O_MUL   = 9'b00011_001_1;
    localparam logic [8:0] O_LU    = 9'b00111_010_0;
    localparam logic [8:0] O_FL    = 9'b11111_110_0;
    localparam logic [8:0] O_FLB   = 9'b11111_110_1;
    localparam logic [8:0] O_MEM   = 9'b00000_000_0;
    localparam logic [8:0] O_MEMB  = 9'b00000_000_1;

    // Input order: {load_use, branch, muldiv, mem_req, mem_ready}
    typedef struct {
        logic [4:0]  in;
        logic [8:0]  exp;
        logic [15:0] exp_stall;
    } vec_t;

    localparam int NV = 31;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] v);
        {load_use_hazard, branch_taken, ex_is_muldiv, mem_req, mem_ready} = v;
    endtask

    initial begin
        vecs[0]  = '{5'b00000, O_NORM,  16'd0};
        vecs[1]  = '{5'b00000, O_NORM,  16'd0};
        vecs[2]  = '{5'b00000, O_NORM,  16'd0};
        vecs[3]  = '{5'b10000, O_LU,    16'd0};
        vecs[4]  = '{5'b00000, O_NORM,  16'd1};
        vecs[5]  = '{5'b00100, O_MUL,   16'd1};
        vecs[6]  = '{5'b00100, O_MUL,   16'd2};
        vecs[7]  = '{5'b00100, O_MUL,   16'd3};
        vecs[8]  = '{5'b00100, O_NORMB, 16'd4};
        vecs[9]  = '{5'b00000, O_NORM,  16'd4};
        vecs[10] = '{5'b01010, O_MEM,   16'd4};
        vecs[11] = '{5'b01010, O_MEM,   16'd5};
        vecs[12] = '{5'b01011, O_FL,    16'd6};
        vecs[13] = '{5'b00000, O_NORM,  16'd6};
        vecs[14] = '{5'b00100, O_MUL,   16'd6};
        vecs[15] = '{5'b00110, O_MEMB,  16'd7};
        vecs[16] = '{5'b00110, O_MEMB,  16'd8};
        vecs[17] = '{5'b00100, O_MUL,   16'd9};
        vecs[18] = '{5'b00100, O_MUL,   16'd10};
        vecs[19] = '{5'b01100, O_FLB,   16'd11};
        vecs[20] = '{5'b00000, O_NORM,  16'd11};
        vecs[21] = '{5'b10010, O_MEM,   16'd11};
        vecs[22] = '{5'b10000, O_MEM,   16'd12};
        vecs[23] = '{5'b10001, O_LU,    16'd13};
        vecs[24] = '{5'b00000, O_NORM,  16'd14};
        vecs[25] = '{5'b11000, O_FL,    16'd14};
        vecs[26] = '{5'b01100, O_MUL,   16'd14};
        vecs[27] = '{5'b00000, O_MUL,   16'd15};
        vecs[28] = '{5'b00000, O_MUL,   16'd16};
        vecs[29] = '{5'b00000, O_NORMB, 16'd17};
        vecs[30] = '{5'b00000, O_NORM,  16'd17};

        reset = 1'b1;
        set_in(5'b00000);
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outs", {7'd0, outs}, 16'd0);
        chk("reset_stall", stall_cycles, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            set_in(vecs[i].in);
            #1;
            $display("vec %0d in=%b out=%b stall=%0d", i, vecs[i].in, outs, stall_cycles);
            chk($sformatf("vec%0d_outs", i), {7'd0, outs}, {7'd0, vecs[i].exp});
            chk($sformatf("vec%0d_stall", i), stall_cycles, vecs[i].exp_stall);
        end

        // Reset while MULDIV has cnt=1.
        @(negedge clk);
        set_in(5'b00100);
        @(negedge clk);
        set_in(5'b00000);
        @(negedge clk);
        #1;
        chk("mid_muldiv_busy", {15'd0, muldiv_busy}, 16'd1);
        reset = 1'b1;
        #1;
        $display("mid-muldiv reset out=%b stall=%0d", outs, stall_cycles);
        chk("mid_reset_outs", {7'd0, outs}, 16'd0);
        chk("mid_reset_stall", stall_cycles, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        $display("post reset out=%b stall=%0d", outs, stall_cycles);
        chk("post_reset_outs", {7'd0, outs}, {7'd0, O_NORM});
        chk("post_reset_stall", stall_cycles, 16'd0);

        // Saturation: hold a memory stall long enough to fill the counter.
        @(negedge clk);
        set_in(5'b00010);
        repeat (65534) @(negedge clk);
        #1;
        $display("sat-1 stall=%0d", stall_cycles);
        chk("sat_minus1", stall_cycles, 16'hFFFE);
        @(negedge clk);
        #1;
        chk("sat_reach", stall_cycles, 16'hFFFF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            $display("sat hold %0d out=%b stall=%0d", k, outs, stall_cycles);
            chk("sat_hold", stall_cycles, 16'hFFFF);
            chk("sat_outs", {7'd0, outs}, {7'd0, O_MEM});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
